fb_arbiter: RTL and testbench

Arbiter and sequencer for the single-port 80x60 RGB565 frame-buffer BRAM. It shares the BRAM between the camera capture writer and the OLED video reader. Display reads win by default; camera writes are absorbed in a small FIFO and drained in idle cycles. Capture freeze, coordinate-to-address translation and out-of-range filtering also live here, so the memory only ever sees legal, serialized accesses.

---
 rtl/fb_arbiter.sv | 136 +++++++++++++
 tb/tb_fb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer BRAM arbiter: serializes camera writes (through a small FIFO)
// and display reads onto one single-port memory, with range filtering and freeze.
module fb_arbiter #(
  parameter int X_SIZE      = 80,
  parameter int Y_SIZE      = 60,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              wr_valid,
  input  logic [6:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [6:0]        rd_x,
  input  logic [6:0]        rd_y,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic              wr_fire, wr_in_range, rd_in_range;
  logic              push, pop, drop, grant_rd;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              s1_valid, s1_in_range, s2_valid, s2_in_range;

  function automatic logic [ADDR_W-1:0] xy_addr(input logic [6:0] x, input logic [6:0] y);
    return ADDR_W'(y) * ADDR_W'(X_SIZE) + ADDR_W'(x);
  endfunction

  assign wr_addr     = xy_addr(wr_x, wr_y);
  assign rd_addr     = xy_addr(rd_x, rd_y);
  assign wr_in_range = (32'(wr_x) < X_SIZE) && (32'(wr_y) < Y_SIZE);
  assign rd_in_range = (32'(rd_x) < X_SIZE) && (32'(rd_y) < Y_SIZE);

  assign full  = (count == CNT_W'(WFIFO_DEPTH));
  assign empty = (count == '0);

  // Ready outputs are forced low while reset is held
  assign wr_ready = rst_n & ~full;
  assign rd_ready = rst_n & ~(full & rd_req);

  assign wr_fire  = wr_valid & wr_ready;
  assign push     = wr_fire & ~freeze & wr_in_range;
  assign drop     = wr_fire & ~freeze & ~wr_in_range;
  assign grant_rd = rd_req & rd_ready;
  assign pop      = ~empty & (full | ~rd_req);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Write pops and read grants are mutually exclusive, so one address mux suffices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= pop | (grant_rd & rd_in_range);
      mem_we <= pop;
      if (pop) begin
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end else if (grant_rd & rd_in_range) begin
        mem_addr <= rd_addr;
      end
    end
  end

  // Read tag pipeline lines up with the BRAM's one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      s2_valid    <= 1'b0;
      s2_in_range <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      s1_valid    <= grant_rd;
      s1_in_range <= grant_rd & rd_in_range;
      s2_valid    <= s1_valid;
      s2_in_range <= s1_in_range;
      rd_valid    <= s2_valid;
      if (s2_valid) rd_data <= s2_in_range ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: a reference model predicts handshakes and
// queues expected BRAM accesses and read responses; a monitor checks them.
module tb_fb_arbiter;

  localparam int X     = 80;
  localparam int Y     = 60;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        freeze = 1'b0;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_x = '0, wr_y = '0, rd_x = '0, rd_y = '0;
  logic [15:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic        wr_ready, rd_ready, rd_valid, mem_en, mem_we;
  logic [15:0] rd_data, mem_wdata, drop_cnt;
  logic [12:0] mem_addr;
  logic [15:0] mem_rdata = '0;

  fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench BRAM returns a fixed pattern per address; writes go only to the scoreboard
  function automatic logic [15:0] rom(input logic [12:0] a);
    if (a == 13'd163) return 16'hF81F;
    return {a, 3'b101} ^ 16'h5A5A;
  endfunction

  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= rom(mem_addr);

  typedef struct { int cyc; logic [15:0] data; } rd_exp_t;
  typedef struct { int cyc; logic [12:0] addr; } acc_exp_t;
  typedef struct { int cyc; logic [12:0] addr; logic [15:0] data; } wr_exp_t;

  rd_exp_t  rd_q[$];
  acc_exp_t acc_q[$];
  wr_exp_t  wr_q[$];

  int checks = 0;
  int failures = 0;
  int m_count = 0;
  int m_drop = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: unexpected event, got 1 expected 0 (cycle %0d)", name, cyc);
  endtask

  // Reference model: handshake prediction and scoreboard pushes
  always @(negedge clk) begin
    bit exp_wr_ready, exp_rd_ready, in, pop;
    int a;
    if (!rst_n) begin
      check_output("reset_outputs",
                   {wr_ready, rd_ready, rd_valid, mem_en, mem_we}, 0);
      check_output("reset_data", {rd_data, mem_wdata}, 0);
      check_output("reset_addr_drop", {mem_addr, drop_cnt}, 0);
      rd_q.delete(); acc_q.delete(); wr_q.delete();
      m_count = 0;
      m_drop = 0;
    end else begin
      exp_wr_ready = (m_count < DEPTH);
      exp_rd_ready = !(m_count == DEPTH && rd_req);
      check_output("wr_ready", wr_ready, exp_wr_ready);
      check_output("rd_ready", rd_ready, exp_rd_ready);
      check_output("drop_cnt", drop_cnt, m_drop);
      pop = (m_count > 0) && (m_count == DEPTH || !rd_req);
      if (rd_req && exp_rd_ready) begin
        in = (rd_x < X) && (rd_y < Y);
        a  = int'(rd_y) * X + int'(rd_x);
        rd_q.push_back('{cyc, in ? rom(13'(a)) : 16'h0});
        if (in) acc_q.push_back('{cyc, 13'(a)});
      end
      if (wr_valid && exp_wr_ready && !freeze) begin
        if (wr_x < X && wr_y < Y) begin
          wr_q.push_back('{cyc, 13'(int'(wr_y) * X + int'(wr_x)), wr_data});
          m_count++;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
      if (pop) m_count--;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a BRAM access or read response
  always @(negedge clk) begin
    rd_exp_t  re;
    acc_exp_t ae;
    wr_exp_t  we;
    #2;
    if (rst_n) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) flag_unexpected("rd_valid");
        else begin
          re = rd_q.pop_front();
          check_output("rd_latency", cyc, re.cyc + 3);
          check_output("rd_data", rd_data, re.data);
        end
      end
      if (mem_en && !mem_we) begin
        if (acc_q.size() == 0) flag_unexpected("mem_read");
        else begin
          ae = acc_q.pop_front();
          check_output("mem_rd_cycle", cyc, ae.cyc + 1);
          check_output("mem_rd_addr", mem_addr, ae.addr);
        end
      end
      if (mem_we) begin
        if (!mem_en) flag_unexpected("mem_we_without_en");
        if (wr_q.size() == 0) flag_unexpected("mem_we");
        else begin
          we = wr_q.pop_front();
          check_output("mem_wr_latency_ok", cyc >= we.cyc + 2, 1);
          check_output("mem_wr_addr", mem_addr, we.addr);
          check_output("mem_wr_data", mem_wdata, we.data);
        end
      end
    end
  end

  bit accepted;

  task automatic apply_stimulus(input bit wv, input int wx, input int wy, input logic [15:0] wd,
                                input bit rr, input int rx, input int ry, input bit fz);
    wr_valid = wv; wr_x = 7'(wx); wr_y = 7'(wy); wr_data = wd;
    rd_req = rr; rd_x = 7'(rx); rd_y = 7'(ry); freeze = fz;
    #3;
    accepted = wv && wr_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic offer_write(input int wx, input int wy, input logic [15:0] wd, input bit rr);
    int tries;
    tries = 0;
    do begin
      apply_stimulus(1, wx, wy, wd, rr, tries % X, 1, 0);
      tries++;
    end while (!accepted && tries < 20);
    if (!accepted) flag_unexpected("write_accept_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (rd_q.size() + acc_q.size() + wr_q.size()) > 0; i++) idle(1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    apply_stimulus(0, 0, 0, 16'h0, 1, 3, 2, 0);
    idle(5);

    apply_stimulus(1, 0, 0, 16'hAAAA, 0, 0, 0, 0);
    apply_stimulus(1, 79, 59, 16'hBBBB, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 16'hCCCC, 0, 0, 0, 0);
    idle(6);

    for (int i = 0; i < 5; i++) offer_write(10 + i, 20, 16'h1000 + 16'(i), 1);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, 16'h0, 1, i, 3, 0);
    drain();

    apply_stimulus(1, 80, 0, 16'h1111, 0, 0, 0, 0);
    apply_stimulus(1, 0, 60, 16'h2222, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 10; i++) apply_stimulus(1, i, i, 16'h3300 + 16'(i), 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 16'h0, 1, 90, 5, 0);
    idle(5);
    check_output("drop_cnt_after_filter", drop_cnt, 2);

    for (int i = 0; i < 3000; i++)
      apply_stimulus($urandom_range(0, 1) == 1, $urandom_range(0, 95), $urandom_range(0, 69),
                     16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 95),
                     $urandom_range(0, 69), $urandom_range(0, 15) == 0);
    drain();

    for (int i = 0; i < 3; i++) apply_stimulus(1, 5 + i, 7, 16'h7700 + 16'(i), 1, i, 9, 0);
    rst_n = 1'b0;
    wr_valid = 1'b0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2 check_output("wr_ready_after_reset", wr_ready, 1);
    idle(10);
    drain();

    check_output("rd_queue_empty", rd_q.size(), 0);
    check_output("wr_queue_empty", wr_q.size(), 0);
    check_output("acc_queue_empty", acc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
